// File: rtl/fx2_fifo_emu_pkg.sv
// rtl/fx2_fifo_emu_pkg.sv - shared widths and endpoint codes for the FX2 slave-FIFO emulator
package fx2_fifo_emu_pkg;

   localparam int USB_DATA_NBIT = 16;
   localparam int USB_ADDR_NBIT = 9;

   localparam logic [1:0] EP2_ADDR = 2'b00;
   localparam logic [1:0] EP6_ADDR = 2'b10;

   function automatic logic ep_hit(input logic [1:0] fifoaddr, input logic [1:0] ep);
      return fifoaddr == ep;
   endfunction

endpackage

// File: rtl/emu_fifo.sv
// rtl/emu_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module emu_fifo #(
   parameter int DATA_NBIT = 16,
   parameter int ADDR_NBIT = 9
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [DATA_NBIT-1:0] wr_data,
   input  logic                 rd_en,
   output logic [DATA_NBIT-1:0] rd_data,
   output logic [ADDR_NBIT:0]   count,
   output logic                 full,
   output logic                 empty
);

   localparam int DEPTH = 1 << ADDR_NBIT;

   logic [DATA_NBIT-1:0] mem [DEPTH];
   logic [ADDR_NBIT-1:0] wr_ptr;
   logic [ADDR_NBIT-1:0] rd_ptr;
   logic                 do_wr;
   logic                 do_rd;

   // count never exceeds DEPTH, so its MSB alone marks full
   assign full    = count[ADDR_NBIT];
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + ADDR_NBIT'(1);
         if (do_rd) rd_ptr <= rd_ptr + ADDR_NBIT'(1);
         count <= count + (ADDR_NBIT+1)'(do_wr) - (ADDR_NBIT+1)'(do_rd);
      end
   end

endmodule

// File: rtl/fx2_fifo_emu.sv
// rtl/fx2_fifo_emu.sv - FX2 slave-FIFO emulator: EP2 host-to-master, EP6 master-to-host with packet commit
module fx2_fifo_emu
   import fx2_fifo_emu_pkg::*;
#(
   parameter int DATA_NBIT = USB_DATA_NBIT,
   parameter int ADDR_NBIT = USB_ADDR_NBIT,
   parameter int PKT_WORDS = 256
) (
   input  logic                 ifclk,
   input  logic                 rst_n,
   input  logic                 sloe,
   input  logic                 slrd,
   input  logic                 slwr,
   input  logic                 pkend,
   input  logic [1:0]           fifoaddr,
   input  logic [DATA_NBIT-1:0] fdata_in,
   output logic [DATA_NBIT-1:0] fdata_out,
   output logic                 fdata_oe,
   output logic                 flagb,
   output logic                 flagc,
   input  logic                 h_wr_vd,
   input  logic [DATA_NBIT-1:0] h_wr_data,
   output logic                 h_wr_rdy,
   output logic                 h_rd_vd,
   output logic [DATA_NBIT-1:0] h_rd_data,
   output logic                 h_rd_eop,
   input  logic                 h_rd_rdy,
   output logic                 err_underrun,
   output logic                 err_overrun
);

   localparam int                 DEPTH   = 1 << ADDR_NBIT;
   localparam logic [ADDR_NBIT:0] PKT_LEN = (ADDR_NBIT+1)'(PKT_WORDS);

   logic ep2_sel;
   logic ep6_sel;

   assign ep2_sel  = ep_hit(fifoaddr, EP2_ADDR);
   assign ep6_sel  = ep_hit(fifoaddr, EP6_ADDR);
   assign fdata_oe = sloe && ep2_sel;

   logic                 ep2_full;
   logic                 ep2_empty;
   logic                 ep2_push;
   logic                 ep2_pop;
   logic [ADDR_NBIT:0]   ep2_count;

   assign h_wr_rdy = !ep2_full;
   assign ep2_push = h_wr_vd && !ep2_full;
   assign ep2_pop  = slrd && ep2_sel && !ep2_empty;

   emu_fifo #(
      .DATA_NBIT (DATA_NBIT),
      .ADDR_NBIT (ADDR_NBIT)
   ) u_ep2 (
      .clk     (ifclk),
      .rst_n   (rst_n),
      .wr_en   (ep2_push),
      .wr_data (h_wr_data),
      .rd_en   (ep2_pop),
      .rd_data (fdata_out),
      .count   (ep2_count),
      .full    (ep2_full),
      .empty   (ep2_empty)
   );

   // EP6 keeps written-but-uncommitted words (ucnt) apart from host-visible ones (ccnt)
   logic [DATA_NBIT-1:0] ep6_mem [DEPTH];
   logic [DEPTH-1:0]     ep6_eop;
   logic [ADDR_NBIT-1:0] ep6_wr_ptr;
   logic [ADDR_NBIT-1:0] ep6_rd_ptr;
   logic [ADDR_NBIT-1:0] ep6_last_ptr;
   logic [ADDR_NBIT:0]   ep6_ucnt;
   logic [ADDR_NBIT:0]   ep6_ccnt;
   logic [ADDR_NBIT:0]   ep6_occ;
   logic [ADDR_NBIT:0]   ep6_ucnt_wr;
   logic                 ep6_full;
   logic                 ep6_wr;
   logic                 ep6_pk;
   logic                 ep6_auto;
   logic                 ep6_commit;
   logic                 ep6_hpop;

   assign ep6_occ      = ep6_ucnt + ep6_ccnt;
   assign ep6_full     = ep6_occ[ADDR_NBIT];
   assign ep6_wr       = slwr && ep6_sel && !ep6_full;
   assign ep6_pk       = pkend && ep6_sel;
   assign ep6_ucnt_wr  = ep6_ucnt + (ADDR_NBIT+1)'(ep6_wr);
   assign ep6_auto     = (ep6_ucnt_wr == PKT_LEN);
   assign ep6_commit   = (ep6_pk && ep6_ucnt_wr != '0) || ep6_auto;
   assign ep6_last_ptr = ep6_wr_ptr - ADDR_NBIT'(1);
   assign ep6_hpop     = h_rd_vd && h_rd_rdy;

   assign h_rd_vd   = (ep6_ccnt != '0);
   assign h_rd_data = ep6_mem[ep6_rd_ptr];
   assign h_rd_eop  = h_rd_vd && ep6_eop[ep6_rd_ptr];

   always_ff @(posedge ifclk) begin
      if (ep6_wr) ep6_mem[ep6_wr_ptr] <= fdata_in;
   end

   always_ff @(posedge ifclk or negedge rst_n) begin
      if (!rst_n) begin
         ep6_eop    <= '0;
         ep6_wr_ptr <= '0;
         ep6_rd_ptr <= '0;
         ep6_ucnt   <= '0;
         ep6_ccnt   <= '0;
      end else begin
         if (ep6_wr) begin
            ep6_eop[ep6_wr_ptr] <= ep6_pk || ep6_auto;
            ep6_wr_ptr          <= ep6_wr_ptr + ADDR_NBIT'(1);
         end else if (ep6_pk && ep6_ucnt != '0) begin
            // pkend without a word closes the packet on the word already written
            ep6_eop[ep6_last_ptr] <= 1'b1;
         end
         if (ep6_hpop) ep6_rd_ptr <= ep6_rd_ptr + ADDR_NBIT'(1);
         if (ep6_commit) begin
            ep6_ucnt <= '0;
            ep6_ccnt <= ep6_ccnt - (ADDR_NBIT+1)'(ep6_hpop) + ep6_ucnt_wr;
         end else begin
            ep6_ucnt <= ep6_ucnt_wr;
            ep6_ccnt <= ep6_ccnt - (ADDR_NBIT+1)'(ep6_hpop);
         end
      end
   end

   always_ff @(posedge ifclk or negedge rst_n) begin
      if (!rst_n) begin
         flagb        <= 1'b0;
         flagc        <= 1'b1;
         err_underrun <= 1'b0;
         err_overrun  <= 1'b0;
      end else begin
         flagb <= (ep2_count != '0);
         flagc <= !ep6_full;
         if (slrd && ep2_sel && ep2_empty) err_underrun <= 1'b1;
         if (slwr && ep6_sel && ep6_full)  err_overrun  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fx2_fifo_emu.sv
// tb/tb_fx2_fifo_emu.sv - directed self-checking bench for fx2_fifo_emu
module tb_fx2_fifo_emu;

   logic        ifclk = 1'b0;
   logic        rst_n;
   logic        sloe, slrd, slwr, pkend;
   logic [1:0]  fifoaddr;
   logic [15:0] fdata_in;
   logic [15:0] fdata_out;
   logic        fdata_oe, flagb, flagc;
   logic        h_wr_vd;
   logic [15:0] h_wr_data;
   logic        h_wr_rdy;
   logic        h_rd_vd;
   logic [15:0] h_rd_data;
   logic        h_rd_eop;
   logic        h_rd_rdy;
   logic        err_underrun, err_overrun;

   int n_cmp = 0;
   int n_bad = 0;

   fx2_fifo_emu dut (
      .ifclk        (ifclk),
      .rst_n        (rst_n),
      .sloe         (sloe),
      .slrd         (slrd),
      .slwr         (slwr),
      .pkend        (pkend),
      .fifoaddr     (fifoaddr),
      .fdata_in     (fdata_in),
      .fdata_out    (fdata_out),
      .fdata_oe     (fdata_oe),
      .flagb        (flagb),
      .flagc        (flagc),
      .h_wr_vd      (h_wr_vd),
      .h_wr_data    (h_wr_data),
      .h_wr_rdy     (h_wr_rdy),
      .h_rd_vd      (h_rd_vd),
      .h_rd_data    (h_rd_data),
      .h_rd_eop     (h_rd_eop),
      .h_rd_rdy     (h_rd_rdy),
      .err_underrun (err_underrun),
      .err_overrun  (err_overrun)
   );

   always #5 ifclk = ~ifclk;

   typedef struct {
      logic       sloe;
      logic [1:0] addr;
      logic       slrd;
      logic       slwr;
      logic       pkend;
      logic       exp_oe;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge ifclk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic host_push(input logic [15:0] d);
      h_wr_vd = 1'b1;
      h_wr_data = d;
      tick();
      h_wr_vd = 1'b0;
   endtask

   task automatic ep6_write(input logic [15:0] d, input logic pk);
      fifoaddr = 2'b10;
      slwr = 1'b1;
      pkend = pk;
      fdata_in = d;
      tick();
      slwr = 1'b0;
      pkend = 1'b0;
   endtask

   task automatic ep6_pkend();
      fifoaddr = 2'b10;
      pkend = 1'b1;
      tick();
      pkend = 1'b0;
   endtask

   task automatic host_pop(input string name, input logic [15:0] d, input logic eop);
      check({name, "_vd"}, h_rd_vd, 1'b1);
      check({name, "_data"}, h_rd_data, d);
      check({name, "_eop"}, h_rd_eop, eop);
      h_rd_rdy = 1'b1;
      tick();
      h_rd_rdy = 1'b0;
   endtask

   task automatic ep2_read(input string name, input logic [15:0] d);
      fifoaddr = 2'b00;
      sloe = 1'b1;
      check(name, fdata_out, d);
      slrd = 1'b1;
      tick();
      slrd = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] w3 [3];
      w3[0] = 16'h1111; w3[1] = 16'h2222; w3[2] = 16'h3333;

      vecs[0] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};

      rst_n = 1'b0;
      sloe = 1'b0; slrd = 1'b0; slwr = 1'b0; pkend = 1'b0;
      fifoaddr = 2'b00; fdata_in = '0;
      h_wr_vd = 1'b0; h_wr_data = '0; h_rd_rdy = 1'b0;
      tick();
      tick();
      check("rst_flagb", flagb, 1'b0);
      check("rst_flagc", flagc, 1'b1);
      check("rst_h_wr_rdy", h_wr_rdy, 1'b1);
      check("rst_h_rd_vd", h_rd_vd, 1'b0);
      check("rst_h_rd_eop", h_rd_eop, 1'b0);
      check("rst_err_underrun", err_underrun, 1'b0);
      check("rst_err_overrun", err_overrun, 1'b0);
      rst_n = 1'b1;
      tick();

      // output-enable decode and ignored strobes on unused addresses
      for (int i = 0; i < 8; i++) begin
         sloe = vecs[i].sloe;
         fifoaddr = vecs[i].addr;
         slrd = vecs[i].slrd;
         slwr = vecs[i].slwr;
         pkend = vecs[i].pkend;
         #1;
         check($sformatf("vec%0d_oe", i), fdata_oe, vecs[i].exp_oe);
         tick();
         slrd = 1'b0; slwr = 1'b0; pkend = 1'b0;
         check($sformatf("vec%0d_err", i), {err_underrun, err_overrun}, 2'b00);
         check($sformatf("vec%0d_flagb", i), flagb, 1'b0);
         check($sformatf("vec%0d_rd_vd", i), h_rd_vd, 1'b0);
      end
      sloe = 1'b0;

      // EP2: three host words read back by the master
      for (int i = 0; i < 3; i++) host_push(w3[i]);
      check("ep2_flagb_full", flagb, 1'b1);
      for (int i = 0; i < 3; i++) ep2_read($sformatf("ep2_rd%0d", i), w3[i]);
      check("ep2_flagb_lag", flagb, 1'b1);
      tick();
      check("ep2_flagb_empty", flagb, 1'b0);

      // underrun, then pointer integrity and simultaneous push/pop at count 1
      fifoaddr = 2'b00; slrd = 1'b1;
      tick();
      slrd = 1'b0;
      check("underrun_flag", err_underrun, 1'b1);
      host_push(16'h5555);
      check("underrun_ptr", fdata_out, 16'h5555);
      h_wr_vd = 1'b1; h_wr_data = 16'h6666; slrd = 1'b1;
      tick();
      h_wr_vd = 1'b0; slrd = 1'b0;
      check("pushpop_data", fdata_out, 16'h6666);
      check("pushpop_flagb0", flagb, 1'b1);
      tick();
      check("pushpop_flagb1", flagb, 1'b1);
      ep2_read("pushpop_rd", 16'h6666);
      sloe = 1'b0;

      // EP6: four words committed by pkend alone
      for (int i = 0; i < 4; i++) ep6_write(16'h00A0 + 16'(i), 1'b0);
      check("pk4_uncommitted", h_rd_vd, 1'b0);
      ep6_pkend();
      for (int i = 0; i < 4; i++) host_pop($sformatf("pk4_%0d", i), 16'h00A0 + 16'(i), i == 3);
      check("pk4_drained", h_rd_vd, 1'b0);

      ep6_pkend();
      check("zlp_ignored", h_rd_vd, 1'b0);

      // pkend together with the last write
      ep6_write(16'h00B0, 1'b0);
      ep6_write(16'h00B1, 1'b1);
      host_pop("pkwr_0", 16'h00B0, 1'b0);
      host_pop("pkwr_1", 16'h00B1, 1'b1);
      check("pkwr_drained", h_rd_vd, 1'b0);

      // auto-commit at 256 words, trailing pkend ignored
      for (int i = 0; i < 256; i++) begin
         ep6_write(16'h1000 + 16'(i), 1'b0);
         if (i == 254) check("auto_pre_commit", h_rd_vd, 1'b0);
      end
      check("auto_commit", h_rd_vd, 1'b1);
      ep6_pkend();
      for (int i = 0; i < 256; i++) host_pop($sformatf("auto_%0d", i), 16'h1000 + 16'(i), i == 255);
      check("auto_no_extra", h_rd_vd, 1'b0);

      // fill to 512 with host stalled, then one dropped write
      for (int i = 0; i < 512; i++) ep6_write(16'h2000 + 16'(i), 1'b0);
      check("full_flagc_lag", flagc, 1'b1);
      check("full_no_overrun", err_overrun, 1'b0);
      ep6_write(16'hDEAD, 1'b0);
      check("full_flagc", flagc, 1'b0);
      check("full_overrun", err_overrun, 1'b1);
      for (int i = 0; i < 512; i++)
         host_pop($sformatf("full_%0d", i), 16'h2000 + 16'(i), (i == 255) || (i == 511));
      check("full_drained", h_rd_vd, 1'b0);
      check("full_flagc_back", flagc, 1'b1);

      // reset mid-packet discards everything
      for (int i = 0; i < 3; i++) ep6_write(16'h0C00 + 16'(i), 1'b0);
      host_push(16'h7777);
      tick();
      check("pre_rst_flagb", flagb, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_flagb", flagb, 1'b0);
      check("mid_rst_err", {err_underrun, err_overrun}, 2'b00);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_h_rd_vd", h_rd_vd, 1'b0);
      check("post_rst_flagc", flagc, 1'b1);
      check("post_rst_flagb", flagb, 1'b0);
      check("post_rst_h_wr_rdy", h_wr_rdy, 1'b1);
      ep6_pkend();
      check("post_rst_discard", h_rd_vd, 1'b0);
      tick();
      check("post_rst_ep2_empty", flagb, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
